// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              stall_if;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, stall_if,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, stall_if,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH_RD,
        DATA_RD,
        DATA_WR,
        ERR
    } owner_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    owner_e            slot1_q, slot2_q, slot1_d;
    logic              if_gnt, d_gnt, d_bad, cmd_ok;
    logic [ADDR_W-1:0] if_word;

    logic              mem_en_q, mem_we_q;
    logic [1:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              d_err_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic [31:0]       if_rdata_q, d_rdata_q;

    always_comb begin
        d_gnt   = rst & bus.d_req
                & ~(bus.if_req & (starve_q == SMAX));
        if_gnt  = rst & bus.if_req & ~d_gnt;
        if_word = bus.if_addr & ~ADDR_W'(3);

        d_bad = 1'b1;
        unique case (bus.d_size)
            2'b11:   d_bad = (bus.d_addr[1:0] != 2'b00);
            2'b10:   d_bad = bus.d_addr[0];
            2'b01:   d_bad = 1'b0;
            default: d_bad = 1'b1;
        endcase
        cmd_ok = if_gnt | (d_gnt & ~d_bad);

        starve_d = starve_q;
        if (!bus.if_req || if_gnt)
            starve_d = '0;
        else if (d_gnt && starve_q != SMAX)
            starve_d = starve_q + 4'd1;

        slot1_d = IDLE;
        if (if_gnt)
            slot1_d = FETCH_RD;
        else if (d_gnt && d_bad)
            slot1_d = ERR;
        else if (d_gnt && bus.d_we)
            slot1_d = DATA_WR;
        else if (d_gnt)
            slot1_d = DATA_RD;
    end

    // Return path: slot2 owns the mem_rdata beat on the wire this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= '0;
            slot1_q     <= IDLE;
            slot2_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_err_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            starve_q <= starve_d;
            slot1_q  <= slot1_d;
            slot2_q  <= slot1_q;
            mem_en_q <= cmd_ok;
            d_err_q  <= d_gnt & d_bad;
            if (if_gnt) begin
                mem_we_q    <= 1'b0;
                mem_size_q  <= 2'b11;
                mem_addr_q  <= if_word;
                mem_wdata_q <= '0;
            end else if (d_gnt && !d_bad) begin
                mem_we_q    <= bus.d_we;
                mem_size_q  <= bus.d_size;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
            end
            if_rvalid_q <= (slot2_q == FETCH_RD);
            d_rvalid_q  <= (slot2_q == DATA_RD);
            if (slot2_q == FETCH_RD)
                if_rdata_q <= bus.mem_rdata;
            if (slot2_q == DATA_RD)
                d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.stall_if  = rst & bus.if_req & ~if_gnt;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a
// cycle-indexed expectation model and a ROM-backed memory.
module tb_mem_port_arbiter;
    localparam int AW   = 10;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] rom [256];

    always @(posedge clk)
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= rom[bus.mem_addr[AW-1:2]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int waits  = 0;
    int g_last = 0;

    logic          e_en  [16];
    logic          e_we  [16];
    logic [1:0]    e_sz  [16];
    logic [AW-1:0] e_ad  [16];
    logic [31:0]   e_wd  [16];
    logic          e_err [16];
    logic          e_irv [16];
    logic          e_drv [16];
    logic [31:0]   e_ird [16];
    logic [31:0]   e_drd [16];
    logic [31:0]   ird_last, drd_last;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_slot(int k);
        e_en[k]  = 0; e_we[k] = 0; e_sz[k] = 0; e_ad[k] = 0;
        e_wd[k]  = 0; e_err[k] = 0; e_irv[k] = 0; e_drv[k] = 0;
        e_ird[k] = 0; e_drd[k] = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) clr_slot(i);
        ird_last = 0;
        drd_last = 0;
        waits    = 0;
    endtask

    task automatic step();
        int k, n1, n3;
        logic ig, dg, bad;
        logic [AW-1:0] fa;
        @(negedge clk);
        if (!rst) clear_model();
        k  = cyc % 16;
        ig = 0;
        dg = 0;
        if (rst) begin
            if (bus.d_req && !(bus.if_req && waits == SMAX)) dg = 1;
            else if (bus.if_req) ig = 1;
        end
        chk("if_gnt", bus.if_gnt, ig);
        chk("d_gnt", bus.d_gnt, dg);
        chk("stall_if", bus.stall_if, rst & bus.if_req & ~ig);
        chk("mem_en", bus.mem_en, e_en[k]);
        if (e_en[k]) begin
            chk("mem_we", bus.mem_we, e_we[k]);
            chk("mem_size", bus.mem_size, e_sz[k]);
            chk("mem_addr", bus.mem_addr, e_ad[k]);
            chk("mem_wdata", bus.mem_wdata, e_wd[k]);
        end
        chk("d_err", bus.d_err, e_err[k]);
        if (e_irv[k]) ird_last = e_ird[k];
        if (e_drv[k]) drd_last = e_drd[k];
        chk("if_rvalid", bus.if_rvalid, e_irv[k]);
        chk("if_rdata", bus.if_rdata, ird_last);
        chk("d_rvalid", bus.d_rvalid, e_drv[k]);
        chk("d_rdata", bus.d_rdata, drd_last);
        clr_slot(k);
        g_last = ig ? 1 : (dg ? 2 : 0);

        if (!bus.if_req || ig) waits = 0;
        else if (dg && waits < SMAX) waits++;
        n1 = (cyc + 1) % 16;
        n3 = (cyc + 3) % 16;
        if (ig) begin
            fa = {bus.if_addr[AW-1:2], 2'b00};
            e_en[n1]  = 1;
            e_we[n1]  = 0;
            e_sz[n1]  = 2'b11;
            e_ad[n1]  = fa;
            e_wd[n1]  = 0;
            e_irv[n3] = 1;
            e_ird[n3] = rom[fa[AW-1:2]];
        end
        if (dg) begin
            bad = (bus.d_size == 0)
               || (bus.d_size == 3 && bus.d_addr % 4 != 0)
               || (bus.d_size == 2 && bus.d_addr % 2 != 0);
            if (bad) begin
                e_err[n1] = 1;
            end else begin
                e_en[n1] = 1;
                e_we[n1] = bus.d_we;
                e_sz[n1] = bus.d_size;
                e_ad[n1] = bus.d_addr;
                e_wd[n1] = bus.d_wdata;
                if (!bus.d_we) begin
                    e_drv[n3] = 1;
                    e_drd[n3] = rom[bus.d_addr[AW-1:2]];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic dload(logic [AW-1:0] a);
        bus.d_req  = 1;
        bus.d_we   = 0;
        bus.d_size = 2'b11;
        bus.d_addr = a;
        bus.d_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[1] = 32'h2008_0005;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_rdata = 0;
        clear_model();

        bus.if_req = 1;
        bus.d_req  = 1;
        step();
        step();
        bus.if_req = 0;
        bus.d_req  = 0;
        rst = 1;
        step();

        // single fetch
        bus.if_req = 1; bus.if_addr = 10'h006;
        step();
        bus.if_req = 0;
        chk("t1_mem_en", bus.mem_en, 1);
        chk("t1_mem_addr", bus.mem_addr, 10'h004);
        chk("t1_mem_size", bus.mem_size, 2'b11);
        step();
        step();
        chk("t1_if_rvalid", bus.if_rvalid, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h2008_0005);
        step();

        // starvation pattern D,D,D,D,I repeated
        bus.if_req = 1; bus.if_addr = 10'h040;
        dload(10'h080);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_grant", g_last, (i % 5 == 4) ? 1 : 2);
        end
        bus.if_req = 0; bus.d_req = 0;
        repeat (4) step();

        // store
        bus.d_req = 1; bus.d_we = 1; bus.d_size = 2'b11;
        bus.d_addr = 10'h010; bus.d_wdata = 32'hDEAD_BEEF;
        step();
        bus.d_req = 0;
        chk("t3_mem_we", bus.mem_we, 1);
        chk("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        repeat (4) step();

        // misaligned half, then illegal size
        for (int j = 0; j < 2; j++) begin
            bus.d_req = 1; bus.d_we = 0;
            bus.d_size = (j == 0) ? 2'b10 : 2'b00;
            bus.d_addr = (j == 0) ? 10'h003 : 10'h000;
            step();
            bus.d_req = 0;
            chk("t4_d_err", bus.d_err, 1);
            chk("t4_mem_en", bus.mem_en, 0);
            step();
            chk("t4_d_err_off", bus.d_err, 0);
            repeat (3) step();
        end

        // alternating back-to-back D, I, D
        dload(10'h020);
        step();
        bus.d_req = 0; bus.if_req = 1; bus.if_addr = 10'h024;
        step();
        bus.if_req = 0;
        dload(10'h028);
        step();
        bus.d_req = 0;
        step();
        chk("t5_d0", bus.d_rdata, rom[8]);
        step();
        chk("t5_i1", bus.if_rdata, rom[9]);
        step();
        chk("t5_d2", bus.d_rdata, rom[10]);
        step();

        // reset while a load is in flight
        dload(10'h030);
        step();
        bus.d_req = 0;
        rst = 0;
        step();
        chk("t6_mem_en", bus.mem_en, 0);
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_d_rvalid", bus.d_rvalid, 0);
        end

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (!bus.if_req || g_last == 1 || $urandom_range(7) == 0) begin
                bus.if_req  = ($urandom_range(2) != 0);
                bus.if_addr = AW'($urandom);
            end
            if (!bus.d_req || g_last == 2 || $urandom_range(7) == 0) begin
                bus.d_req   = ($urandom_range(2) != 0);
                bus.d_we    = $urandom_range(1);
                bus.d_size  = ($urandom_range(4) == 0)
                            ? 2'($urandom) : 2'b11;
                bus.d_addr  = ($urandom_range(3) == 0)
                            ? AW'($urandom) : AW'($urandom) & ~AW'(3);
                bus.d_wdata = $urandom;
            end
            rst = ($urandom_range(199) != 0);
            step();
            rst = 1;
        end
        bus.if_req = 0; bus.d_req = 0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
